multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller that runs the RISC-V datapath as a multi-cycle machine over one shared memory port, replacing the single-cycle opcode-only decode. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB states and stalls on a memory ready handshake. Per state it drives the datapath enables and muxes. It also counts retired instructions.

## Interface
- OPCODE_W, 7, opcode field width
- CNT_W, 32, retired-instruction counter width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- OP_i  input  7  opcode; IR[6:0], valid from DECODE onward
- Mem_Ready_i  input  1  memory accepted/completed current request this cycle
- PC_Write_o  output  1  unconditional PC load
- PC_Write_Cond_o  output  1  PC load gated by datapath branch-taken flag
- PC_Src_o  output  2  0=PC+4, 1=PC_old+imm (branch/JAL), 2=rs1+imm (JALR)
- IR_Write_o  output  1  latch fetched word into IR and PC_old
- Mem_Read_o  output  1  memory read request (fetch or load)
- Mem_Write_o  output  1  memory write request (store)
- I_or_D_o  output  1  0=address from PC, 1=address from ALU result
- ALU_Src_A_o  output  1  0=rs1, 1=PC_old
- ALU_Src_B_o  output  1  0=rs2, 1=immediate
- ALU_Op_o  output  3  ALU operation class
- Reg_Write_o  output  1  register file write
- Mem_to_Reg_o  output  2  0=ALU result, 1=memory data, 2=PC_old+4
- Illegal_Instr_o  output  1  one-cycle pulse on an unknown opcode
- Retired_Count_o  output  CNT_W  instructions completed since reset

## Operation
- Opcodes: R=0x33, I-logic=0x13, LOAD=0x03, STORE=0x23, LUI=0x37, BRANCH=0x63, JAL=0x6F, JALR=0x67.
- ALU_Op codes: R 000, I-logic/LOAD 001, STORE 110, LUI 100, BRANCH 111, JAL/JALR 101.
- **FETCH:** Mem_Read=1, I_or_D=0.
  - Holds while Mem_Ready_i=0.
  - On Mem_Ready_i=1: IR_Write=1, PC_Write=1, PC_Src=0, then go to DECODE.
- **DECODE:** 1 cycle. All writes are 0.
  - Illegal opcode: Illegal_Instr_o=1, go to FETCH. Not counted as retired.
  - Otherwise go to EXECUTE.
- **EXECUTE:** ALU_Op per opcode.
  - ALU_Src_B=1 for every opcode except R and BRANCH.
  - ALU_Src_A=1 for JAL.
  - BRANCH: PC_Write_Cond=1, PC_Src=1, retire, go to FETCH.
  - JAL/JALR: PC_Write=1, PC_Src=1 or 2, go to WB.
  - LOAD/STORE: go to MEM.
  - R/I/LUI: go to WB.
- **MEM:** I_or_D=1, Mem_Read (LOAD) or Mem_Write (STORE) held until Mem_Ready_i=1.
  - STORE: retire on ready, go to FETCH.
  - LOAD: go to WB on ready.
- **WB:** Reg_Write=1, Mem_to_Reg = 1 for LOAD, 2 for JAL/JALR, 0 otherwise. Retire, go to FETCH.
- **Retire:** Retired_Count_o increments by 1 in the retire cycle. Wraps modulo 2^CNT_W.
- **Outputs:** Moore decode of the state plus the opcode latched at DECODE. Any signal not listed for a state is 0.

## Timing
- **Reset:** while reset=1, state=FETCH, Retired_Count_o=0, and every output is 0 (forced, including Mem_Read_o).
  - The first fetch request appears in the first cycle after reset falls.
- **Cycles per instruction with zero wait states:** BRANCH 3; R, I-logic, LUI, STORE, JAL, JALR 4; LOAD 5.
- **Wait states:** each wait cycle in FETCH or MEM adds 1 cycle. Request signals stay stable until ready.
- **Mem_Ready_i outside FETCH/MEM:** ignored.
- **Reset mid-operation:** any pending request is dropped that cycle and no write enable asserts. The next state is FETCH.
- **OP_i sampling:** OP_i is sampled only in DECODE and held internally until the instruction retires.
  - OP_i changes in later states have no effect.
- **Counter wrap:** all-ones + retire = 0.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - opcode localparams;
  - ALU_Op codes;
  - PC_Src and Mem_to_Reg encodings;
  - the FSM state enum (FETCH, DECODE, EXECUTE, MEM, WB).
- Sub-module `rv_op_class`: combinational map from opcode to ALU_Op, ALU_Src_B, instruction class, and illegal flag. The FSM instantiates it once.
- State register, latched opcode and retire counter live in the top block.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 during reset; Mem_Read_o=1, I_or_D_o=0 in the first cycle after release; Retired_Count_o=0.
- ADD (0x33), Mem_Ready_i tied 1: 4 cycles; Reg_Write_o=1 with Mem_to_Reg_o=0 in cycle 4; counter increments to 1.
- LW (0x03) with 2 wait cycles in MEM: 7 cycles total; Mem_Read_o and I_or_D_o held 3 cycles in MEM; WB has Mem_to_Reg_o=1.
- BEQ (0x63): PC_Write_Cond_o=1, PC_Src_o=1, ALU_Op_o=111 in cycle 3; Reg_Write_o never 1; next cycle is FETCH.
- Opcode 0x7F: Illegal_Instr_o pulses 1 cycle in DECODE; counter unchanged; FETCH follows.
- Reset asserted during a STORE's MEM wait: Mem_Write_o=0 in that cycle; FETCH after release; counter=0. Separately, preload counter to all-ones then retire one instruction: wraps to 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multi-cycle RISC-V sequencing controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [2:0] ALU_R      = 3'b000;
    localparam logic [2:0] ALU_I      = 3'b001;
    localparam logic [2:0] ALU_STORE  = 3'b110;
    localparam logic [2:0] ALU_LUI    = 3'b100;
    localparam logic [2:0] ALU_BRANCH = 3'b111;
    localparam logic [2:0] ALU_JUMP   = 3'b101;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_REL  = 2'd1;
    localparam logic [1:0] PC_SRC_JALR = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_LUI,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/rv_op_class.sv
// rtl/rv_op_class.sv - opcode to instruction class, ALU operation and operand-B select
module rv_op_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic       illegal
);

    always_comb begin
        op_class  = CLS_ILLEGAL;
        alu_op    = ALU_R;
        alu_src_b = 1'b0;
        case (op)
            OP_R: begin
                op_class = CLS_R;
            end
            OP_I: begin
                op_class  = CLS_I;
                alu_op    = ALU_I;
                alu_src_b = 1'b1;
            end
            OP_LOAD: begin
                op_class  = CLS_LOAD;
                alu_op    = ALU_I;
                alu_src_b = 1'b1;
            end
            OP_STORE: begin
                op_class  = CLS_STORE;
                alu_op    = ALU_STORE;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                op_class  = CLS_LUI;
                alu_op    = ALU_LUI;
                alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                op_class = CLS_BRANCH;
                alu_op   = ALU_BRANCH;
            end
            OP_JAL: begin
                op_class  = CLS_JAL;
                alu_op    = ALU_JUMP;
                alu_src_b = 1'b1;
            end
            OP_JALR: begin
                op_class  = CLS_JALR;
                alu_op    = ALU_JUMP;
                alu_src_b = 1'b1;
            end
            default: begin
                op_class = CLS_ILLEGAL;
            end
        endcase
        illegal = (op_class == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - FETCH/DECODE/EXECUTE/MEM/WB sequencer over one shared memory port
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] OP_i,
    input  logic                Mem_Ready_i,
    output logic                PC_Write_o,
    output logic                PC_Write_Cond_o,
    output logic [1:0]          PC_Src_o,
    output logic                IR_Write_o,
    output logic                Mem_Read_o,
    output logic                Mem_Write_o,
    output logic                I_or_D_o,
    output logic                ALU_Src_A_o,
    output logic                ALU_Src_B_o,
    output logic [2:0]          ALU_Op_o,
    output logic                Reg_Write_o,
    output logic [1:0]          Mem_to_Reg_o,
    output logic                Illegal_Instr_o,
    output logic [CNT_W-1:0]    Retired_Count_o
);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] op_sel;
    logic [CNT_W-1:0]    retired;
    logic                retire;

    op_class_t  op_class;
    logic [2:0] cls_alu_op;
    logic       cls_src_b;
    logic       cls_illegal;

    // DECODE classifies the live opcode; later states use the copy latched there.
    assign op_sel = (state == S_DECODE) ? OP_i : op_q;

    rv_op_class u_op_class (
        .op        (op_sel),
        .op_class  (op_class),
        .alu_op    (cls_alu_op),
        .alu_src_b (cls_src_b),
        .illegal   (cls_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= '0;
            retired <= '0;
        end else begin
            if (retire)
                retired <= retired + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (Mem_Ready_i)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q  <= OP_i;
                    state <= cls_illegal ? S_FETCH : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op_class)
                        CLS_BRANCH:          state <= S_FETCH;
                        CLS_LOAD, CLS_STORE: state <= S_MEM;
                        default:             state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (Mem_Ready_i)
                        state <= (op_class == CLS_STORE) ? S_FETCH : S_WB;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Reset masks every control line so a pending request is dropped immediately.
    always_comb begin
        PC_Write_o      = 1'b0;
        PC_Write_Cond_o = 1'b0;
        PC_Src_o        = PC_SRC_SEQ;
        IR_Write_o      = 1'b0;
        Mem_Read_o      = 1'b0;
        Mem_Write_o     = 1'b0;
        I_or_D_o        = 1'b0;
        ALU_Src_A_o     = 1'b0;
        ALU_Src_B_o     = 1'b0;
        ALU_Op_o        = ALU_R;
        Reg_Write_o     = 1'b0;
        Mem_to_Reg_o    = WB_ALU;
        Illegal_Instr_o = 1'b0;
        retire          = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    Mem_Read_o = 1'b1;
                    if (Mem_Ready_i) begin
                        IR_Write_o = 1'b1;
                        PC_Write_o = 1'b1;
                        PC_Src_o   = PC_SRC_SEQ;
                    end
                end
                S_DECODE: begin
                    Illegal_Instr_o = cls_illegal;
                end
                S_EXECUTE: begin
                    ALU_Op_o    = cls_alu_op;
                    ALU_Src_B_o = cls_src_b;
                    ALU_Src_A_o = (op_class == CLS_JAL);
                    case (op_class)
                        CLS_BRANCH: begin
                            PC_Write_Cond_o = 1'b1;
                            PC_Src_o        = PC_SRC_REL;
                            retire          = 1'b1;
                        end
                        CLS_JAL: begin
                            PC_Write_o = 1'b1;
                            PC_Src_o   = PC_SRC_REL;
                        end
                        CLS_JALR: begin
                            PC_Write_o = 1'b1;
                            PC_Src_o   = PC_SRC_JALR;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    I_or_D_o    = 1'b1;
                    Mem_Read_o  = (op_class == CLS_LOAD);
                    Mem_Write_o = (op_class == CLS_STORE);
                    retire      = Mem_Ready_i && (op_class == CLS_STORE);
                end
                S_WB: begin
                    Reg_Write_o = 1'b1;
                    retire      = 1'b1;
                    case (op_class)
                        CLS_LOAD:          Mem_to_Reg_o = WB_MEM;
                        CLS_JAL, CLS_JALR: Mem_to_Reg_o = WB_LINK;
                        default:           Mem_to_Reg_o = WB_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign Retired_Count_o = reset ? '0 : retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized scoreboard bench for the multi-cycle sequencer
module tb_multicycle_control_fsm;

    localparam int CW = 8;

    localparam logic [6:0] ADD = 7'h33, ADDI = 7'h13, LW = 7'h03, SW = 7'h23;
    localparam logic [6:0] LUI = 7'h37, BEQ = 7'h63, JAL = 7'h6F, JALR = 7'h67;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    op = 7'h0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic          alu_src_a, alu_src_b, reg_write, illegal;
    logic [1:0]    pc_src, mem_to_reg;
    logic [2:0]    alu_op;
    logic [CW-1:0] retired;

    multicycle_control_fsm #(.OPCODE_W(7), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .OP_i            (op),
        .Mem_Ready_i     (mem_ready),
        .PC_Write_o      (pc_write),
        .PC_Write_Cond_o (pc_write_cond),
        .PC_Src_o        (pc_src),
        .IR_Write_o      (ir_write),
        .Mem_Read_o      (mem_read),
        .Mem_Write_o     (mem_write),
        .I_or_D_o        (i_or_d),
        .ALU_Src_A_o     (alu_src_a),
        .ALU_Src_B_o     (alu_src_b),
        .ALU_Op_o        (alu_op),
        .Reg_Write_o     (reg_write),
        .Mem_to_Reg_o    (mem_to_reg),
        .Illegal_Instr_o (illegal),
        .Retired_Count_o (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       irw;
        logic       mr;
        logic       mw;
        logic       iod;
        logic       sa;
        logic       sb;
        logic [2:0] aop;
        logic       rw;
        logic [1:0] m2r;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        ctl_t          ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          exp_e;
    ctl_t          got;
    int            checks = 0;
    int            errors = 0;
    int            cycle_no = 0;
    int            retired_total = 0;
    logic [CW-1:0] cnt_model = '0;

    assign got = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, i_or_d,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal};

    // One clock of stimulus plus the control word the architecture demands for it.
    task automatic cyc(input logic r, input logic rdy, input logic [6:0] o, input ctl_t c,
                       input logic ret);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        mem_ready = rdy;
        op        = o;
        e.ctl     = r ? ctl_t'(0) : c;
        e.cnt     = r ? '0 : cnt_model;
        sb_q.push_back(e);
        if (r) begin
            cnt_model     = '0;
            retired_total = 0;
        end else if (ret) begin
            cnt_model     = cnt_model + 1'b1;
            retired_total = retired_total + 1;
        end
    endtask

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [6:0] o, input int fetch_waits, input int mem_waits,
                             input bit reset_in_mem);
        ctl_t c;
        bit   legal;
        legal = (o == ADD) || (o == ADDI) || (o == LW) || (o == SW) ||
                (o == LUI) || (o == BEQ) || (o == JAL) || (o == JALR);
        for (int i = 0; i < fetch_waits; i++) begin
            c = '0; c.mr = 1'b1;
            cyc(1'b0, 1'b0, rnd_op(), c, 1'b0);
        end
        c = '0; c.mr = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.pcs = 2'd0;
        cyc(1'b0, 1'b1, rnd_op(), c, 1'b0);
        c = '0; c.ill = !legal;
        cyc(1'b0, rnd_bit(), o, c, 1'b0);
        if (!legal) return;

        c = '0;
        case (o)
            ADD:      c.aop = 3'b000;
            ADDI, LW: c.aop = 3'b001;
            SW:       c.aop = 3'b110;
            LUI:      c.aop = 3'b100;
            BEQ:      c.aop = 3'b111;
            default:  c.aop = 3'b101;
        endcase
        c.sb = !(o == ADD || o == BEQ);
        c.sa = (o == JAL);
        if (o == BEQ) begin c.pcwc = 1'b1; c.pcs = 2'd1; end
        if (o == JAL) begin c.pcw = 1'b1; c.pcs = 2'd1; end
        if (o == JALR) begin c.pcw = 1'b1; c.pcs = 2'd2; end
        cyc(1'b0, rnd_bit(), rnd_op(), c, o == BEQ);
        if (o == BEQ) return;

        if (o == LW || o == SW) begin
            c = '0; c.iod = 1'b1; c.mr = (o == LW); c.mw = (o == SW);
            for (int i = 0; i < mem_waits; i++)
                cyc(1'b0, 1'b0, rnd_op(), c, 1'b0);
            if (reset_in_mem) begin
                cyc(1'b1, rnd_bit(), rnd_op(), c, 1'b0);
                return;
            end
            cyc(1'b0, 1'b1, rnd_op(), c, o == SW);
            if (o == SW) return;
        end

        c = '0; c.rw = 1'b1;
        c.m2r = (o == LW) ? 2'd1 : ((o == JAL || o == JALR) ? 2'd2 : 2'd0);
        cyc(1'b0, rnd_bit(), rnd_op(), c, 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_e    = sb_q.pop_front();
                cycle_no = cycle_no + 1;
                checks   = checks + 1;
                if (got !== exp_e.ctl) begin
                    errors = errors + 1;
                    $display("FAIL ctl cycle %0d: got %h required %h", cycle_no, got, exp_e.ctl);
                end
                checks = checks + 1;
                if (retired !== exp_e.cnt) begin
                    errors = errors + 1;
                    $display("FAIL retired cycle %0d: got %0d required %0d", cycle_no, retired,
                             exp_e.cnt);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [6:0] pool [10];

    initial begin
        pool = '{ADD, ADDI, LW, SW, LUI, BEQ, JAL, JALR, 7'h7F, 7'h00};
        for (int i = 0; i < 3; i++)
            cyc(1'b1, rnd_bit(), rnd_op(), ctl_t'(0), 1'b0);
        run_instr(ADD, 0, 0, 1'b0);
        run_instr(LW, 0, 2, 1'b0);
        run_instr(BEQ, 0, 0, 1'b0);
        run_instr(7'h7F, 0, 0, 1'b0);
        run_instr(SW, 1, 2, 1'b1);
        run_instr(JAL, 1, 0, 1'b0);
        while (retired_total < 270)
            run_instr(pool[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2),
                      1'b0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(posedge clk);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
